// File: rtl/skipring_mc.sv
// skipring_mc: multi-channel clock-skip generator.
// Each channel walks a phase ring of programmable length. A high phase of iCLK
// is suppressed on oCLK[c] when that phase's mask bit is set. New
// configurations load either immediately or at the ring wrap, through a
// per-channel shadow register. Each channel counts its suppressed cycles.
// All state changes on the falling edge of iCLK, so oCLK is glitch-free.
// Ports:
//   iCLK   clock (falling edge active)   nRST  sync active-low reset
//   E      per-channel run/skip enable
//   WR, wSEL, wMASK, wL, wPH, wIMM       configuration write
//   oCLK   gated clocks   oB0    phase-0 flags   oPEND  deferred load pending
//   oCNT   saturating skip counters, channel c at [c*CW +: CW]
module skipring_mc #(
    parameter int unsigned   LEN     = 16,
    parameter int unsigned   CH      = 2,
    parameter int unsigned   CW      = 16,
    parameter logic [LEN-1:0] defMASK = '0,
    localparam int unsigned  LW      = $clog2(LEN),
    localparam int unsigned  SW      = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic              iCLK,
    input  logic              nRST,
    input  logic [CH-1:0]     E,
    input  logic              WR,
    input  logic [SW-1:0]     wSEL,
    input  logic [LEN-1:0]    wMASK,
    input  logic [LW-1:0]     wL,
    input  logic [LW-1:0]     wPH,
    input  logic              wIMM,
    output logic [CH-1:0]     oCLK,
    output logic [CH-1:0]     oB0,
    output logic [CH-1:0]     oPEND,
    output logic [CH*CW-1:0]  oCNT
);

    // Start phase beyond the written length falls back to phase 0.
    logic [LW-1:0] wph_clamped;
    assign wph_clamped = (wPH > wL) ? '0 : wPH;

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic [LEN-1:0] mask_q, mask_d, smask_q, smask_d;
        logic [LW-1:0]  l_q, l_d, ph_q, ph_d;
        logic [LW-1:0]  sl_q, sl_d, sph_q, sph_d;
        logic [CW-1:0]  cnt_q, cnt_d;
        logic           pend_q, pend_d;
        logic           sel, wrap, skip;

        // Out-of-range wSEL never matches any channel index.
        assign sel  = WR && (wSEL == SW'(c));
        assign wrap = E[c] && (ph_q == l_q);
        assign skip = mask_q[ph_q];

        // Next-state: immediate or wrap-coincident write wins, then shadow
        // capture, then advance with wrap-time shadow apply.
        always_comb begin
            mask_d  = mask_q;
            l_d     = l_q;
            ph_d    = ph_q;
            cnt_d   = cnt_q;
            pend_d  = pend_q;
            smask_d = smask_q;
            sl_d    = sl_q;
            sph_d   = sph_q;
            if (sel && (wIMM || wrap)) begin
                mask_d = wMASK;
                l_d    = wL;
                ph_d   = wph_clamped;
                cnt_d  = '0;
                pend_d = 1'b0;
            end else begin
                if (sel) begin
                    smask_d = wMASK;
                    sl_d    = wL;
                    sph_d   = wph_clamped;
                    pend_d  = 1'b1;
                end
                if (E[c]) begin
                    if (wrap && pend_q) begin
                        mask_d = smask_q;
                        l_d    = sl_q;
                        ph_d   = sph_q;
                        cnt_d  = '0;
                        pend_d = 1'b0;
                    end else begin
                        ph_d = wrap ? '0 : ph_q + LW'(1);
                        if (skip && (cnt_q != '1)) begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
            end
        end

        // Channel state register, falling edge, synchronous reset.
        always_ff @(negedge iCLK) begin
            if (!nRST) begin
                mask_q  <= defMASK;
                l_q     <= LW'(LEN - 1);
                ph_q    <= '0;
                cnt_q   <= '0;
                pend_q  <= 1'b0;
                smask_q <= '0;
                sl_q    <= '0;
                sph_q   <= '0;
            end else begin
                mask_q  <= mask_d;
                l_q     <= l_d;
                ph_q    <= ph_d;
                cnt_q   <= cnt_d;
                pend_q  <= pend_d;
                smask_q <= smask_d;
                sl_q    <= sl_d;
                sph_q   <= sph_d;
            end
        end

        // State is stable through the high phase, so this gate cannot glitch.
        assign oCLK[c]           = iCLK & ~(E[c] & skip);
        assign oB0[c]            = (ph_q == '0);
        assign oPEND[c]          = pend_q;
        assign oCNT[c*CW +: CW]  = cnt_q;
    end

endmodule

// File: tb/tb_skipring_mc.sv
module tb_skipring_mc;

    logic        iCLK, nRST, WR, wIMM;
    logic [2:0]  E;
    logic [1:0]  wSEL;
    logic [15:0] wMASK;
    logic [3:0]  wL, wPH;
    logic [2:0]  oCLK, oB0, oPEND;
    logic [11:0] oCNT;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic       clk;
        logic       b0;
        logic       pend;
        logic [3:0] cnt;
    } exp_t;

    exp_t q[$];

    skipring_mc #(.LEN(16), .CH(3), .CW(4), .defMASK(16'h0000)) dut (
        .iCLK(iCLK), .nRST(nRST), .E(E), .WR(WR), .wSEL(wSEL),
        .wMASK(wMASK), .wL(wL), .wPH(wPH), .wIMM(wIMM),
        .oCLK(oCLK), .oB0(oB0), .oPEND(oPEND), .oCNT(oCNT)
    );

    initial iCLK = 1'b1;
    always #5 iCLK = ~iCLK;

    function automatic exp_t mk(input logic c, input logic b, input logic p, input int n);
        exp_t r;
        r.clk  = c;
        r.b0   = b;
        r.pend = p;
        r.cnt  = 4'(n);
        return r;
    endfunction

    function automatic exp_t obs(input int ch);
        return mk(oCLK[ch], oB0[ch], oPEND[ch], int'(oCNT[ch*4 +: 4]));
    endfunction

    // Just after the active (falling) edge: safe point to drive inputs.
    task automatic step();
        @(negedge iCLK);
        #1;
    endtask

    // Inside the high phase: sample outputs.
    task automatic to_high();
        @(posedge iCLK);
        #1;
    endtask

    task automatic drive_wr(input logic [1:0] s, input logic [15:0] m,
                            input logic [3:0] l, input logic [3:0] p, input logic imm);
        WR = 1'b1; wSEL = s; wMASK = m; wL = l; wPH = p; wIMM = imm;
    endtask

    task automatic test_reset();
        E = 3'b111; nRST = 1'b0; WR = 1'b0; wSEL = '0; wMASK = '0;
        wL = '0; wPH = '0; wIMM = 1'b0;
        step(); step();
        to_high();
        tests_run++;
        if ({oB0, oPEND, oCNT, oCLK} !== {3'b111, 3'b000, 12'h000, 3'b111}) begin
            tests_failed++;
            $display("FAIL reset_high: got b0=%b pend=%b cnt=%h clk=%b want b0=111 pend=000 cnt=000 clk=111",
                     oB0, oPEND, oCNT, oCLK);
        end
        step();
        tests_run++;
        if (oCLK !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_low_clk: got %b want 000", oCLK);
        end
        nRST = 1'b1;
    endtask

    task automatic test_immediate();
        exp_t e, g;
        drive_wr(2'd0, 16'h0005, 4'd3, 4'd0, 1'b1);
        step();
        WR = 1'b0;
        for (int i = 0; i < 8; i++) q.push_back(mk((i % 2) != 0, (i % 4) == 0, 1'b0, i / 2 + (i % 2)));
        for (int i = 0; i < 8; i++) begin
            to_high();
            e = q.pop_front();
            g = obs(0);
            tests_run++;
            if (g !== e || oCLK[1] !== 1'b1) begin
                tests_failed++;
                $display("FAIL imm[%0d]: got %b ch1clk=%b want %b ch1clk=1", i, g, oCLK[1], e);
            end
            step();
        end
        tests_run++;
        if (oCNT[3:0] !== 4'd4 || oCNT[7:4] !== 4'd0) begin
            tests_failed++;
            $display("FAIL imm_cnt: got ch0=%0d ch1=%0d want ch0=4 ch1=0", oCNT[3:0], oCNT[7:4]);
        end
    endtask

    task automatic test_deferred();
        exp_t e, g;
        drive_wr(2'd0, 16'h0020, 4'd7, 4'd0, 1'b1);
        step();
        WR = 1'b0;
        step(); step(); step();
        q.push_back(mk(1, 0, 0, 0));
        q.push_back(mk(1, 0, 1, 0));
        q.push_back(mk(0, 0, 1, 0));
        q.push_back(mk(1, 0, 1, 1));
        q.push_back(mk(1, 0, 1, 1));
        q.push_back(mk(1, 1, 0, 0));
        q.push_back(mk(0, 0, 0, 0));
        q.push_back(mk(1, 1, 0, 1));
        q.push_back(mk(0, 0, 0, 1));
        drive_wr(2'd0, 16'h0002, 4'd1, 4'd0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            to_high();
            e = q.pop_front();
            g = obs(0);
            tests_run++;
            if (g !== e) begin
                tests_failed++;
                $display("FAIL deferred[%0d]: got %b want %b", i, g, e);
            end
            step();
            WR = 1'b0;
        end
        tests_run++;
        if (oCNT[3:0] !== 4'd2) begin
            tests_failed++;
            $display("FAIL deferred_cnt: got %0d want 2", oCNT[3:0]);
        end
    endtask

    task automatic test_stall();
        exp_t e, g;
        drive_wr(2'd1, 16'hFFFF, 4'd15, 4'd0, 1'b1);
        step();
        WR = 1'b0;
        for (int i = 0; i < 3; i++) q.push_back(mk(0, i == 0, 0, i));
        q.push_back(mk(0, 0, 0, 3));
        for (int i = 0; i < 6; i++) q.push_back(mk(1, 0, 1, 4));
        for (int k = 4; k < 16; k++) q.push_back(mk(0, 0, 1, k));
        q.push_back(mk(1, 1, 0, 0));
        for (int i = 0; i < 23; i++) begin
            if (i == 3) drive_wr(2'd1, 16'h0000, 4'd3, 4'd0, 1'b0);
            to_high();
            e = q.pop_front();
            g = obs(1);
            tests_run++;
            if (g !== e) begin
                tests_failed++;
                $display("FAIL stall[%0d]: got %b want %b", i, g, e);
            end
            step();
            WR = 1'b0;
            E[1] = !((i + 1 >= 4) && (i + 1 <= 9));
        end
        E = 3'b111;
    endtask

    task automatic test_saturation();
        exp_t e, g;
        drive_wr(2'd2, 16'hFFFF, 4'd15, 4'd0, 1'b1);
        step();
        WR = 1'b0;
        for (int i = 0; i < 20; i++) q.push_back(mk(0, (i % 16) == 0, 0, (i > 15) ? 15 : i));
        for (int i = 0; i < 20; i++) begin
            to_high();
            e = q.pop_front();
            g = obs(2);
            tests_run++;
            if (g !== e) begin
                tests_failed++;
                $display("FAIL sat[%0d]: got %b want %b", i, g, e);
            end
            step();
        end
        tests_run++;
        if (oCNT[11:8] !== 4'd15) begin
            tests_failed++;
            $display("FAIL sat_hold: got %0d want 15", oCNT[11:8]);
        end
    endtask

    task automatic test_corner();
        exp_t e, g;
        // Write to a nonexistent channel.
        drive_wr(2'd3, 16'hFFFF, 4'd0, 4'd0, 1'b1);
        step();
        WR = 1'b0;
        to_high();
        tests_run++;
        if (oCNT[11:8] !== 4'd15 || oCLK[2] !== 1'b0 || oCLK[1] !== 1'b1 ||
            oCNT[7:4] !== 4'd0 || oPEND !== 3'b000) begin
            tests_failed++;
            $display("FAIL bad_sel: got cnt=%h clk=%b pend=%b want cnt2=f cnt1=0 clk2=0 clk1=1 pend=000",
                     oCNT, oCLK, oPEND);
        end
        step();
        // Start phase beyond length is clamped to 0.
        drive_wr(2'd1, 16'h0001, 4'd2, 4'd5, 1'b1);
        step();
        WR = 1'b0;
        q.push_back(mk(0, 1, 0, 0));
        q.push_back(mk(1, 0, 0, 1));
        q.push_back(mk(1, 0, 0, 1));
        q.push_back(mk(0, 1, 0, 1));
        for (int i = 0; i < 4; i++) begin
            to_high();
            e = q.pop_front();
            g = obs(1);
            tests_run++;
            if (g !== e) begin
                tests_failed++;
                $display("FAIL clamp[%0d]: got %b want %b", i, g, e);
            end
            step();
        end
        // Reset discards a pending load.
        drive_wr(2'd1, 16'hFFFF, 4'd15, 4'd0, 1'b0);
        step();
        WR = 1'b0;
        to_high();
        tests_run++;
        if (oPEND[1] !== 1'b1) begin
            tests_failed++;
            $display("FAIL pend_set: got %b want 1", oPEND[1]);
        end
        step();
        nRST = 1'b0;
        step();
        nRST = 1'b1;
        to_high();
        tests_run++;
        if ({oPEND, oB0, oCNT} !== {3'b000, 3'b111, 12'h000}) begin
            tests_failed++;
            $display("FAIL rst_pend: got pend=%b b0=%b cnt=%h want 000 111 000", oPEND, oB0, oCNT);
        end
        step();
        for (int i = 1; i < 18; i++) q.push_back(mk(1, (i % 16) == 0, 0, 0));
        for (int i = 1; i < 18; i++) begin
            to_high();
            e = q.pop_front();
            g = obs(1);
            tests_run++;
            if (g !== e) begin
                tests_failed++;
                $display("FAIL rst_shadow[%0d]: got %b want %b", i, g, e);
            end
            step();
        end
    endtask

    task automatic test_wrap_write();
        drive_wr(2'd1, 16'h0000, 4'd1, 4'd0, 1'b1);
        step();
        WR = 1'b0;
        step();
        // ch1 now at PH=1 == L: the next edge is a wrap.
        drive_wr(2'd1, 16'h0001, 4'd1, 4'd0, 1'b0);
        step();
        WR = 1'b0;
        to_high();
        tests_run++;
        if (oPEND[1] !== 1'b0 || oCLK[1] !== 1'b0 || oB0[1] !== 1'b1) begin
            tests_failed++;
            $display("FAIL wrap_write: got pend=%b clk=%b b0=%b want pend=0 clk=0 b0=1",
                     oPEND[1], oCLK[1], oB0[1]);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_immediate();
        test_deferred();
        test_stall();
        test_saturation();
        test_corner();
        test_wrap_write();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
